// File: rtl/register_file_pkg.sv
// Shared defaults and helpers for the register bank.
// Optional write-through forwarding is selected with the REGFILE_BYPASS_EN macro.
package register_file_pkg;

    localparam int RF_WIDTH  = 16;
    localparam int RF_DEPTH  = 8;
    localparam int RF_ADDR_W = 3;
    localparam logic [RF_WIDTH-1:0] RF_RESET_VAL = '0;

    // True when an address selects a word that physically exists.
    function automatic bit rf_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Write/read bus of the register bank: one write port, two combinational read ports.
interface register_file_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) ();
    logic              load;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  in;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  out_a;
    logic [WIDTH-1:0]  out_b;

    modport master (
        output load, waddr, in, raddr_a, raddr_b,
        input  out_a, out_b
    );

    modport slave (
        input  load, waddr, in, raddr_a, raddr_b,
        output out_a, out_b
    );
endinterface

// File: rtl/register_file_register_n.sv
// Single WIDTH-bit word with load enable and synchronous active-high reset.
module register_n #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             reset,
    input  logic             clk
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset)
            r_q <= RESET_VAL;
        else if (load)
            r_q <= in;
    end

    assign out = r_q;
endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register bank, one synchronous write port and two combinational read ports.
// Define REGFILE_BYPASS_EN to forward write data to a read port addressing the word being written.
module register_file
    import register_file_pkg::*;
#(
    parameter int               WIDTH     = RF_WIDTH,
    parameter int               DEPTH     = RF_DEPTH,
    parameter int               ADDR_W    = RF_ADDR_W,
    parameter int               ZERO_REG  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    register_file_if.slave         bus
);

    logic [DEPTH-1:0][WIDTH-1:0] w_words;
    logic [DEPTH-1:0]            w_wen;
    logic                        w_fwd_en;

    // Word 0 with ZERO_REG keeps a physical register that never loads and resets to 0.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        localparam bit               IS_ZERO = (ZERO_REG != 0) && (i == 0);
        localparam logic [WIDTH-1:0] RST_V   = IS_ZERO ? {WIDTH{1'b0}} : RESET_VAL;

        assign w_wen[i] = bus.load && (bus.waddr == ADDR_W'(i)) && !IS_ZERO;

        register_n #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RST_V)
        ) u_reg (
            .out   (w_words[i]),
            .in    (bus.in),
            .load  (w_wen[i]),
            .reset (reset),
            .clk   (clk)
        );
    end

`ifdef REGFILE_BYPASS_EN
    assign w_fwd_en = bus.load && !reset;
`else
    assign w_fwd_en = 1'b0;
`endif

    // Only in-range, non-zero-register addresses ever match, so everything else reads 0
    // and is never forwarded.
    function automatic logic [WIDTH-1:0] f_read(
        input logic [ADDR_W-1:0]           addr,
        input logic [DEPTH-1:0][WIDTH-1:0] words,
        input logic                        fwd_en,
        input logic [ADDR_W-1:0]           waddr,
        input logic [WIDTH-1:0]            wdata
    );
        logic [WIDTH-1:0] v_rd;
        v_rd = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (addr == ADDR_W'(k) && !((ZERO_REG != 0) && (k == 0)))
                v_rd = (fwd_en && (waddr == addr)) ? wdata : words[k];
        end
        return v_rd;
    endfunction

    assign bus.out_a = f_read(bus.raddr_a, w_words, w_fwd_en, bus.waddr, bus.in);
    assign bus.out_b = f_read(bus.raddr_b, w_words, w_fwd_en, bus.waddr, bus.in);

endmodule
